// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl -- Mac-side IO bus engine.
//
// Takes a level request (IOREQ) from the fast-bus controller and runs one
// MC68000-style bus cycle on the slow Mac bus. Every bus transition is paced
// by C8M edges, which are seen through a 2-FF synchronizer in the FCLK domain.
// Terminations: DTACK, VPA/E (6800-synchronous, via nVMA) and BERR.
//
// Optional feature macro: IOBUS_TIMEOUT_EN
//   defined   -> a TO_W-bit counter aborts a cycle with a bus error after
//                TO_CYC C8M rising edges spent waiting for a responder.
//   undefined -> no counter; the engine waits for a responder indefinitely.
//
// Ports
//   FCLK      in   fast clock, all flops on its rising edge
//   nRES      in   asynchronous active-low reset
//   C8M, E    in   Mac clocks (async, synchronized here)
//   IOREQ     in   request level from the fast bus (used only in IDLE)
//   nWE, nLDS, nUDS  in  CPU cycle attributes, captured at accept
//   IOnDTACK, IOnVPA, IOnBERR  in  Mac responder inputs (async, synchronized)
//   IOACTV    out  cycle in progress
//   nBERRMac  out  bus error result of the last cycle (low = error)
//   IOnAS, IOnLDS, IOnUDS, IORnW  out  Mac bus strobes / direction
//   nAOE      out  address / write-data buffer output enable
//   DLE       out  read data latch enable, one FCLK pulse
//   nVMA      out  valid memory address for VPA cycles

module io_bus_ctrl #(
  parameter int TO_CYC = 255,
  parameter int TO_W   = 8
) (
  input  logic FCLK,
  input  logic nRES,
  input  logic C8M,
  input  logic E,
  input  logic IOREQ,
  input  logic nWE,
  input  logic nLDS,
  input  logic nUDS,
  input  logic IOnDTACK,
  input  logic IOnVPA,
  input  logic IOnBERR,
  output logic IOACTV,
  output logic nBERRMac,
  output logic IOnAS,
  output logic IOnLDS,
  output logic IOnUDS,
  output logic IORnW,
  output logic nAOE,
  output logic DLE,
  output logic nVMA
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_W0, ST_S1, ST_S2, ST_S4, ST_VW, ST_VE, ST_S6, ST_S7
  } state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYC);

  // Synchronizer bit order: {C8M, E, IOnDTACK, IOnVPA, IOnBERR}.
  // Reset values match the idle level of each line so that leaving reset
  // never fakes a responder.
  localparam logic [4:0] SYNC_RST = 5'b00111;

  logic [4:0] async_in;
  logic [4:0] sync1_q, sync2_q;
  logic       c8m_prev_q, e_prev_q;

  assign async_in = {C8M, E, IOnDTACK, IOnVPA, IOnBERR};

  logic c8m_s, e_s, dtack, vpa, berr;
  assign c8m_s = sync2_q[4];
  assign e_s   = sync2_q[3];
  assign dtack = ~sync2_q[2];
  assign vpa   = ~sync2_q[1];
  assign berr  = ~sync2_q[0];

  // One-FCLK edge pulses on the synchronized clocks.
  logic c_rise, c_fall, e_rise, e_fall;
  assign c_rise = c8m_s & ~c8m_prev_q;
  assign c_fall = ~c8m_s & c8m_prev_q;
  assign e_rise = e_s & ~e_prev_q;
  assign e_fall = ~e_s & e_prev_q;

  state_t state_q, state_d;
  logic   we_n_q, we_n_d;       // captured nWE (1 = read)
  logic   lds_n_q, lds_n_d;     // captured strobes
  logic   uds_n_q, uds_n_d;
  logic   err_q, err_d;         // current cycle ended in a bus error
  logic   actv_q, actv_d;
  logic   berr_mac_q, berr_mac_d;
  logic   as_n_q, as_n_d;
  logic   lds_out_q, lds_out_d;
  logic   uds_out_q, uds_out_d;
  logic   rnw_q, rnw_d;
  logic   aoe_n_q, aoe_n_d;
  logic   dle_q, dle_d;
  logic   vma_n_q, vma_n_d;
`ifdef IOBUS_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_to_limit;
  assign unused_to_limit = ^TO_LIMIT;
`endif

  always_comb begin
    state_d    = state_q;
    we_n_d     = we_n_q;
    lds_n_d    = lds_n_q;
    uds_n_d    = uds_n_q;
    err_d      = err_q;
    actv_d     = actv_q;
    berr_mac_d = berr_mac_q;
    as_n_d     = as_n_q;
    lds_out_d  = lds_out_q;
    uds_out_d  = uds_out_q;
    rnw_d      = rnw_q;
    aoe_n_d    = aoe_n_q;
    dle_d      = 1'b0;
    vma_n_d    = vma_n_q;
`ifdef IOBUS_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (IOREQ) begin
          we_n_d     = nWE;
          lds_n_d    = nLDS;
          uds_n_d    = nUDS;
          err_d      = 1'b0;
          actv_d     = 1'b1;
          aoe_n_d    = 1'b0;
          rnw_d      = nWE;
          berr_mac_d = 1'b1;
          state_d    = ST_W0;
        end
      end
      ST_W0: if (c_rise) state_d = ST_S1;
      ST_S1: begin
        if (c_fall) begin
          as_n_d = 1'b0;
          // Reads drive data strobes together with AS; writes wait a half
          // cycle so the write data is stable first.
          if (we_n_q) begin
            lds_out_d = lds_n_q;
            uds_out_d = uds_n_q;
          end
`ifdef IOBUS_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          state_d = ST_S2;
        end
      end
      ST_S2: begin
        if (c_rise) begin
          if (!we_n_q) begin
            lds_out_d = lds_n_q;
            uds_out_d = uds_n_q;
          end
          state_d = ST_S4;
        end
      end
      ST_S4: begin
        if (c_fall) begin
          // BERR wins over DTACK: a simultaneous pair is a bus error.
          if (berr) begin
            err_d   = 1'b1;
            state_d = ST_S7;
          end else if (dtack) begin
            state_d = ST_S6;
          end else if (vpa) begin
            state_d = ST_VW;
          end
        end
      end
      ST_VW: begin
        if (e_rise) begin
          vma_n_d = 1'b0;
          state_d = ST_VE;
        end
      end
      ST_VE: begin
        if (e_fall) begin
          vma_n_d = 1'b1;
          state_d = ST_S6;
        end
      end
      ST_S6: begin
        if (c_rise) begin
          dle_d   = we_n_q & ~err_q;
          state_d = ST_S7;
        end
      end
      ST_S7: begin
        if (c_fall) begin
          as_n_d     = 1'b1;
          lds_out_d  = 1'b1;
          uds_out_d  = 1'b1;
          aoe_n_d    = 1'b1;
          rnw_d      = 1'b1;
          actv_d     = 1'b0;
          berr_mac_d = ~err_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef IOBUS_TIMEOUT_EN
    // Timeout overrides any termination seen on the same FCLK.
    if (state_q == ST_S4 || state_q == ST_VW || state_q == ST_VE) begin
      if (to_cnt_q == TO_LIMIT) begin
        err_d   = 1'b1;
        vma_n_d = 1'b1;
        state_d = ST_S7;
      end else if (c_rise) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) begin
      sync1_q    <= SYNC_RST;
      sync2_q    <= SYNC_RST;
      c8m_prev_q <= 1'b0;
      e_prev_q   <= 1'b0;
      state_q    <= ST_IDLE;
      we_n_q     <= 1'b1;
      lds_n_q    <= 1'b1;
      uds_n_q    <= 1'b1;
      err_q      <= 1'b0;
      actv_q     <= 1'b0;
      berr_mac_q <= 1'b1;
      as_n_q     <= 1'b1;
      lds_out_q  <= 1'b1;
      uds_out_q  <= 1'b1;
      rnw_q      <= 1'b1;
      aoe_n_q    <= 1'b1;
      dle_q      <= 1'b0;
      vma_n_q    <= 1'b1;
`ifdef IOBUS_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      sync1_q    <= async_in;
      sync2_q    <= sync1_q;
      c8m_prev_q <= c8m_s;
      e_prev_q   <= e_s;
      state_q    <= state_d;
      we_n_q     <= we_n_d;
      lds_n_q    <= lds_n_d;
      uds_n_q    <= uds_n_d;
      err_q      <= err_d;
      actv_q     <= actv_d;
      berr_mac_q <= berr_mac_d;
      as_n_q     <= as_n_d;
      lds_out_q  <= lds_out_d;
      uds_out_q  <= uds_out_d;
      rnw_q      <= rnw_d;
      aoe_n_q    <= aoe_n_d;
      dle_q      <= dle_d;
      vma_n_q    <= vma_n_d;
`ifdef IOBUS_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign IOACTV   = actv_q;
  assign nBERRMac = berr_mac_q;
  assign IOnAS    = as_n_q;
  assign IOnLDS   = lds_out_q;
  assign IOnUDS   = uds_out_q;
  assign IORnW    = rnw_q;
  assign nAOE     = aoe_n_q;
  assign DLE      = dle_q;
  assign nVMA     = vma_n_q;

endmodule
